// File: rtl/iq_pkg.sv
// rtl/iq_pkg.sv - shared IQ constants, default sizes and width helper
package iq_pkg;

    localparam int IQ_DEF_SAMPLE_W = 12;
    localparam int IQ_DEF_CHANNELS = 2;

    localparam logic IQ_SEL_I = 1'b0;
    localparam logic IQ_SEL_Q = 1'b1;

    // Width of a channel index; a single channel still gets a 1-bit field.
    function automatic int iq_ch_w(input int channels);
        return (channels > 1) ? $clog2(channels) : 1;
    endfunction

endpackage

// File: rtl/iq_word_fifo2.sv
// rtl/iq_word_fifo2.sv - two-entry word buffer carrying channel count and swap flag
module iq_word_fifo2 #(
    parameter int DATA_W = 48,
    parameter int CNT_W  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic [CNT_W-1:0]  push_cnt,
    input  logic              push_swap,
    input  logic              pop,
    output logic [1:0]        count,
    output logic [DATA_W-1:0] head_data,
    output logic [CNT_W-1:0]  head_cnt,
    output logic              head_swap
);

    logic [DATA_W-1:0] data_mem [2];
    logic [CNT_W-1:0]  cnt_mem  [2];
    logic              swap_mem [2];
    logic              wr_ptr;
    logic              rd_ptr;

    // Pointers and occupancy; a push and pop in the same edge leave count unchanged.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push)
                wr_ptr <= ~wr_ptr;
            if (pop)
                rd_ptr <= ~rd_ptr;
            count <= count + 2'(push) - 2'(pop);
        end
    end

    // Payload storage is deliberately left unreset; occupancy alone decides validity.
    always_ff @(posedge clk) begin
        if (push) begin
            data_mem[wr_ptr] <= push_data;
            cnt_mem[wr_ptr]  <= push_cnt;
            swap_mem[wr_ptr] <= push_swap;
        end
    end

    assign head_data = data_mem[rd_ptr];
    assign head_cnt  = cnt_mem[rd_ptr];
    assign head_swap = swap_mem[rd_ptr];

endmodule

// File: rtl/iq_lane_serializer.sv
// rtl/iq_lane_serializer.sv - packed I/Q word to sample stream serializer; IQ_SER_SWAP_EN adds per-word Q-first ordering
module iq_lane_serializer
    import iq_pkg::*;
#(
    parameter int SAMPLE_W = IQ_DEF_SAMPLE_W,
    parameter int CHANNELS = IQ_DEF_CHANNELS,
    localparam int CNT_W   = $clog2(CHANNELS) + 1,
    localparam int CH_W    = iq_ch_w(CHANNELS)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [2*CHANNELS*SAMPLE_W-1:0] s_data_i,
    input  logic [CNT_W-1:0]               s_ch_cnt_i,
    input  logic                           s_valid_i,
    output logic                           s_ready_o,
`ifdef IQ_SER_SWAP_EN
    input  logic                           s_swap_i,
`endif
    output logic [SAMPLE_W-1:0]            m_data_o,
    output logic                           m_iqsel_o,
    output logic [CH_W-1:0]                m_ch_o,
    output logic                           m_last_o,
    output logic                           m_valid_o,
    input  logic                           m_ready_i
);

    // Lane counter walks 0 .. 2*cnt-1, which always fits in CNT_W bits.
    localparam int LW     = CNT_W;
    localparam int DATA_W = 2 * CHANNELS * SAMPLE_W;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CHANNELS);

    logic              rst_r;
    logic              s_swap;
    logic [CNT_W-1:0]  cnt_clamped;
    logic              push;
    logic              pop;
    logic [1:0]        count;
    logic [DATA_W-1:0] head_data;
    logic [CNT_W-1:0]  head_cnt;
    logic              head_swap;
    logic [LW-1:0]     lane_cnt;
    logic [LW-1:0]     sel_pos;
    logic [CNT_W:0]    last_idx;

`ifdef IQ_SER_SWAP_EN
    assign s_swap = s_swap_i;
`else
    assign s_swap = 1'b0;
`endif

    // Delayed reset keeps the slave side closed for one cycle after reset release.
    always_ff @(posedge clk) begin
        rst_r <= rst;
    end

    assign s_ready_o   = (count != 2'd2) & ~rst & ~rst_r;
    assign push        = s_valid_i & s_ready_o;
    assign cnt_clamped = ((s_ch_cnt_i == '0) || (s_ch_cnt_i > CNT_MAX)) ? CNT_MAX : s_ch_cnt_i;

    iq_word_fifo2 #(
        .DATA_W (DATA_W),
        .CNT_W  (CNT_W)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (s_data_i),
        .push_cnt  (cnt_clamped),
        .push_swap (s_swap),
        .pop       (pop),
        .count     (count),
        .head_data (head_data),
        .head_cnt  (head_cnt),
        .head_swap (head_swap)
    );

    assign m_valid_o = (count != 2'd0) & ~rst;
    assign last_idx  = {head_cnt, 1'b0} - (CNT_W + 1)'(1);
    assign m_last_o  = m_valid_o & ({1'b0, lane_cnt} == last_idx);
    assign pop       = m_valid_o & m_ready_i & m_last_o;

    // Swapping only flips which half of the pair goes first; channel order is unchanged.
    assign sel_pos   = lane_cnt ^ LW'(head_swap);
    assign m_iqsel_o = sel_pos[0] ? IQ_SEL_Q : IQ_SEL_I;
    assign m_ch_o    = CH_W'(lane_cnt >> 1);

    // Sample mux: pick the SAMPLE_W slice of the head word addressed by sel_pos.
    always_comb begin
        m_data_o = '0;
        for (int p = 0; p < 2 * CHANNELS; p++) begin
            if (sel_pos == LW'(p))
                m_data_o = head_data[p*SAMPLE_W +: SAMPLE_W];
        end
    end

    // Lane counter advances per master transfer and wraps to 0 as the head word retires.
    always_ff @(posedge clk) begin
        if (rst)
            lane_cnt <= '0;
        else if (m_valid_o && m_ready_i)
            lane_cnt <= m_last_o ? '0 : lane_cnt + LW'(1);
    end

endmodule

// File: tb/tb_iq_lane_serializer.sv
// tb/tb_iq_lane_serializer.sv - directed and randomized-stall bench for iq_lane_serializer
module tb_iq_lane_serializer;

    logic        clk;
    logic        rst;
    logic [47:0] s_data;
    logic [1:0]  s_ch_cnt;
    logic        s_valid;
    logic        s_ready;
`ifdef IQ_SER_SWAP_EN
    logic        s_swap;
`endif
    logic [11:0] m_data;
    logic        m_iqsel;
    logic [0:0]  m_ch;
    logic        m_last;
    logic        m_valid;
    logic        m_ready;

    int nvec = 0;
    int nerr = 0;

    localparam logic [47:0] WORD_A = 48'h444_333_222_111;
    localparam logic [47:0] WORD_B = 48'hDDD_CCC_BBB_AAA;

    iq_lane_serializer #(
        .SAMPLE_W (12),
        .CHANNELS (2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .s_data_i   (s_data),
        .s_ch_cnt_i (s_ch_cnt),
        .s_valid_i  (s_valid),
        .s_ready_o  (s_ready),
`ifdef IQ_SER_SWAP_EN
        .s_swap_i   (s_swap),
`endif
        .m_data_o   (m_data),
        .m_iqsel_o  (m_iqsel),
        .m_ch_o     (m_ch),
        .m_last_o   (m_last),
        .m_valid_o  (m_valid),
        .m_ready_i  (m_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic test_reset();
        rst = 1'b1; s_valid = 1'b0; m_ready = 1'b0; s_data = '0; s_ch_cnt = 2'd0;
`ifdef IQ_SER_SWAP_EN
        s_swap = 1'b0;
`endif
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); #1;
            nvec++;
            if ({m_valid, m_last, s_ready} !== 3'b000) begin
                nerr++;
                $display("FAIL reset_outputs cyc%0d: got valid/last/ready=%b%b%b want 000", i, m_valid, m_last, s_ready);
            end
        end
        @(negedge clk); rst = 1'b0; #1;
        nvec++;
        if (s_ready !== 1'b0) begin
            nerr++; $display("FAIL reset_release_ready: got %b want 0", s_ready);
        end
        @(negedge clk); #1;
        nvec++;
        if (s_ready !== 1'b1 || m_valid !== 1'b0) begin
            nerr++; $display("FAIL post_reset_idle: got ready=%b valid=%b want ready=1 valid=0", s_ready, m_valid);
        end
    endtask

    task automatic test_basic();
        logic [14:0] exp_s [4];
        exp_s = '{{1'b0, 1'b0, 1'b0, 12'h111}, {1'b0, 1'b0, 1'b1, 12'h222},
                  {1'b0, 1'b1, 1'b0, 12'h333}, {1'b1, 1'b1, 1'b1, 12'h444}};
        @(negedge clk);
        s_data = WORD_A; s_ch_cnt = 2'd2; s_valid = 1'b1; m_ready = 1'b1; #1;
        nvec++;
        if (s_ready !== 1'b1 || m_valid !== 1'b0) begin
            nerr++; $display("FAIL basic_accept: got ready=%b valid=%b want 1 0", s_ready, m_valid);
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); s_valid = 1'b0; #1;
            nvec++;
            if (m_valid !== 1'b1 || {m_last, m_ch, m_iqsel, m_data} !== exp_s[i]) begin
                nerr++;
                $display("FAIL basic_sample%0d: got valid=%b {last,ch,iq,data}=%h want valid=1 %h", i, m_valid, {m_last, m_ch, m_iqsel, m_data}, exp_s[i]);
            end
        end
        @(negedge clk); #1;
        nvec++;
        if (m_valid !== 1'b0) begin
            nerr++; $display("FAIL basic_drain: got valid=%b want 0", m_valid);
        end
    endtask

    task automatic test_cnt();
        logic [14:0] exp_s [6];
        logic [1:0]  cnt_in [2];
        int          n_s [2];
        int          base;
        exp_s = '{{1'b0, 1'b0, 1'b0, 12'h111}, {1'b1, 1'b0, 1'b1, 12'h222},
                  {1'b0, 1'b0, 1'b0, 12'h111}, {1'b0, 1'b0, 1'b1, 12'h222},
                  {1'b0, 1'b1, 1'b0, 12'h333}, {1'b1, 1'b1, 1'b1, 12'h444}};
        cnt_in = '{2'd1, 2'd0};
        n_s    = '{2, 4};
        base   = 0;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            s_data = WORD_A; s_ch_cnt = cnt_in[k]; s_valid = 1'b1; m_ready = 1'b1; #1;
            for (int i = 0; i < n_s[k]; i++) begin
                @(negedge clk); s_valid = 1'b0; #1;
                nvec++;
                if (m_valid !== 1'b1 || {m_last, m_ch, m_iqsel, m_data} !== exp_s[base+i]) begin
                    nerr++;
                    $display("FAIL cnt%0d_sample%0d: got valid=%b {last,ch,iq,data}=%h want valid=1 %h", cnt_in[k], i, m_valid, {m_last, m_ch, m_iqsel, m_data}, exp_s[base+i]);
                end
            end
            @(negedge clk); #1;
            nvec++;
            if (m_valid !== 1'b0) begin
                nerr++; $display("FAIL cnt%0d_drain: got valid=%b want 0", cnt_in[k], m_valid);
            end
            base += n_s[k];
        end
    endtask

    task automatic test_back_to_back();
        logic [14:0] exp_s [8];
        logic        exp_rdy [8];
        exp_s = '{{1'b0, 1'b0, 1'b0, 12'h111}, {1'b0, 1'b0, 1'b1, 12'h222},
                  {1'b0, 1'b1, 1'b0, 12'h333}, {1'b1, 1'b1, 1'b1, 12'h444},
                  {1'b0, 1'b0, 1'b0, 12'hAAA}, {1'b0, 1'b0, 1'b1, 12'hBBB},
                  {1'b0, 1'b1, 1'b0, 12'hCCC}, {1'b1, 1'b1, 1'b1, 12'hDDD}};
        exp_rdy = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        @(negedge clk);
        s_data = WORD_A; s_ch_cnt = 2'd2; s_valid = 1'b1; m_ready = 1'b1; #1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (i == 0) s_data = WORD_B;
            else        s_valid = 1'b0;
            #1;
            nvec++;
            if (m_valid !== 1'b1 || {m_last, m_ch, m_iqsel, m_data} !== exp_s[i] || s_ready !== exp_rdy[i]) begin
                nerr++;
                $display("FAIL b2b_cycle%0d: got valid=%b sample=%h ready=%b want valid=1 sample=%h ready=%b", i, m_valid, {m_last, m_ch, m_iqsel, m_data}, s_ready, exp_s[i], exp_rdy[i]);
            end
        end
        @(negedge clk); #1;
        nvec++;
        if (m_valid !== 1'b0) begin
            nerr++; $display("FAIL b2b_drain: got valid=%b want 0", m_valid);
        end

        // Push lands on the same edge as the last-sample pop of a single-entry FIFO.
        @(negedge clk);
        s_data = WORD_A; s_ch_cnt = 2'd1; s_valid = 1'b1; #1;
        @(negedge clk); s_valid = 1'b0; #1;
        nvec++;
        if ({m_valid, m_last, m_ch, m_iqsel, m_data} !== {1'b1, 15'h0111}) begin
            nerr++; $display("FAIL pushpop_a0: got %h want %h", {m_valid, m_last, m_ch, m_iqsel, m_data}, {1'b1, 15'h0111});
        end
        @(negedge clk); s_data = WORD_B; s_ch_cnt = 2'd1; s_valid = 1'b1; #1;
        nvec++;
        if ({m_valid, m_last, m_ch, m_iqsel, m_data} !== {1'b1, 15'h5222} || s_ready !== 1'b1) begin
            nerr++; $display("FAIL pushpop_a1: got %h ready=%b want %h ready=1", {m_valid, m_last, m_ch, m_iqsel, m_data}, s_ready, {1'b1, 15'h5222});
        end
        @(negedge clk); s_valid = 1'b0; #1;
        nvec++;
        if ({m_valid, m_last, m_ch, m_iqsel, m_data} !== {1'b1, 15'h0AAA}) begin
            nerr++; $display("FAIL pushpop_b0: got %h want %h", {m_valid, m_last, m_ch, m_iqsel, m_data}, {1'b1, 15'h0AAA});
        end
        @(negedge clk); #1;
        nvec++;
        if ({m_valid, m_last, m_ch, m_iqsel, m_data} !== {1'b1, 15'h5BBB}) begin
            nerr++; $display("FAIL pushpop_b1: got %h want %h", {m_valid, m_last, m_ch, m_iqsel, m_data}, {1'b1, 15'h5BBB});
        end
        @(negedge clk); #1;
        nvec++;
        if (m_valid !== 1'b0) begin
            nerr++; $display("FAIL pushpop_drain: got valid=%b want 0", m_valid);
        end
    endtask

    task automatic test_random_stall();
        logic [14:0] exp_q [$];
        logic [14:0] got;
        logic [14:0] prev_out;
        logic [47:0] word;
        logic [1:0]  cnt;
        logic        pending;
        logic        prev_stall;
        int          ce;
        int          sent;
        int          cycles;
        pending = 1'b0; prev_stall = 1'b0; prev_out = '0; sent = 0; cycles = 0;
        word = '0; cnt = '0;
        while ((sent < 1000 || pending || exp_q.size() != 0) && cycles < 30000) begin
            @(negedge clk);
            cycles++;
            if (!pending) s_valid = 1'b0;
            if (!pending && sent < 1000 && $urandom_range(0, 3) != 0) begin
                word = {16'($urandom), 32'($urandom)};
                cnt  = 2'($urandom_range(0, 3));
                s_data = word; s_ch_cnt = cnt; s_valid = 1'b1; pending = 1'b1;
            end
            m_ready = 1'($urandom_range(0, 1));
            #1;
            got = {m_last, m_ch, m_iqsel, m_data};
            if (prev_stall) begin
                nvec++;
                if (m_valid !== 1'b1 || got !== prev_out) begin
                    nerr++; $display("FAIL stall_hold cyc%0d: got valid=%b sample=%h want valid=1 sample=%h", cycles, m_valid, got, prev_out);
                end
            end
            if (s_valid && s_ready) begin
                ce = (cnt == 2'd0 || cnt > 2'd2) ? 2 : int'(cnt);
                for (int c = 0; c < ce; c++) begin
                    exp_q.push_back({1'b0, 1'(c), 1'b0, word[(2*c)*12 +: 12]});
                    exp_q.push_back({(c == ce - 1), 1'(c), 1'b1, word[(2*c+1)*12 +: 12]});
                end
                sent++;
                pending = 1'b0;
            end
            if (m_valid && m_ready) begin
                nvec++;
                if (exp_q.size() == 0) begin
                    nerr++; $display("FAIL stream_extra cyc%0d: got sample=%h want none", cycles, got);
                end else begin
                    if (got !== exp_q[0]) begin
                        nerr++; $display("FAIL stream_order cyc%0d: got sample=%h want %h", cycles, got, exp_q[0]);
                    end
                    void'(exp_q.pop_front());
                end
            end
            prev_stall = m_valid && !m_ready;
            prev_out   = got;
        end
        s_valid = 1'b0;
        nvec++;
        if (cycles >= 30000 || sent != 1000 || exp_q.size() != 0) begin
            nerr++; $display("FAIL stream_complete: got words=%0d pending_samples=%0d cycles=%0d want 1000 0 <30000", sent, exp_q.size(), cycles);
        end
        @(negedge clk); #1;
        nvec++;
        if (m_valid !== 1'b0) begin
            nerr++; $display("FAIL stream_drain: got valid=%b want 0", m_valid);
        end
    endtask

    task automatic test_mid_reset();
        @(negedge clk);
        s_data = WORD_A; s_ch_cnt = 2'd2; s_valid = 1'b1; m_ready = 1'b1; #1;
        @(negedge clk); s_valid = 1'b0; #1;
        @(negedge clk); #1;
        nvec++;
        if ({m_valid, m_last, m_ch, m_iqsel, m_data} !== {1'b1, 15'h1222}) begin
            nerr++; $display("FAIL midrst_second: got %h want %h", {m_valid, m_last, m_ch, m_iqsel, m_data}, {1'b1, 15'h1222});
        end
        @(negedge clk); rst = 1'b1; #1;
        nvec++;
        if ({m_valid, m_last, s_ready} !== 3'b000) begin
            nerr++; $display("FAIL midrst_during: got valid/last/ready=%b%b%b want 000", m_valid, m_last, s_ready);
        end
        @(negedge clk); rst = 1'b0; #1;
        nvec++;
        if ({m_valid, m_last, s_ready} !== 3'b000) begin
            nerr++; $display("FAIL midrst_after: got valid/last/ready=%b%b%b want 000", m_valid, m_last, s_ready);
        end
        @(negedge clk);
        s_data = WORD_B; s_ch_cnt = 2'd2; s_valid = 1'b1; #1;
        nvec++;
        if (s_ready !== 1'b1 || m_valid !== 1'b0) begin
            nerr++; $display("FAIL midrst_reopen: got ready=%b valid=%b want 1 0", s_ready, m_valid);
        end
        @(negedge clk); s_valid = 1'b0; #1;
        nvec++;
        if ({m_valid, m_last, m_ch, m_iqsel, m_data} !== {1'b1, 15'h0AAA}) begin
            nerr++; $display("FAIL midrst_restart: got %h want %h", {m_valid, m_last, m_ch, m_iqsel, m_data}, {1'b1, 15'h0AAA});
        end
        for (int i = 0; i < 4; i++) @(negedge clk);
        #1;
        nvec++;
        if (m_valid !== 1'b0) begin
            nerr++; $display("FAIL midrst_drain: got valid=%b want 0", m_valid);
        end
    endtask

`ifdef IQ_SER_SWAP_EN
    task automatic test_swap();
        logic [14:0] exp_s [4];
        exp_s = '{{1'b0, 1'b0, 1'b1, 12'h222}, {1'b0, 1'b0, 1'b0, 12'h111},
                  {1'b0, 1'b1, 1'b1, 12'h444}, {1'b1, 1'b1, 1'b0, 12'h333}};
        @(negedge clk);
        s_data = WORD_A; s_ch_cnt = 2'd2; s_swap = 1'b1; s_valid = 1'b1; m_ready = 1'b1; #1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); s_valid = 1'b0; s_swap = 1'b0; #1;
            nvec++;
            if (m_valid !== 1'b1 || {m_last, m_ch, m_iqsel, m_data} !== exp_s[i]) begin
                nerr++;
                $display("FAIL swap_sample%0d: got valid=%b {last,ch,iq,data}=%h want valid=1 %h", i, m_valid, {m_last, m_ch, m_iqsel, m_data}, exp_s[i]);
            end
        end
        @(negedge clk); #1;
        nvec++;
        if (m_valid !== 1'b0) begin
            nerr++; $display("FAIL swap_drain: got valid=%b want 0", m_valid);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_cnt();
        test_back_to_back();
        test_random_stall();
        test_mid_reset();
`ifdef IQ_SER_SWAP_EN
        test_swap();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
